// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide sequencer.
//   OP_*      : bit positions inside the one-hot req_op vector
//   state_t   : sequencer states
//   DIV_ITERS : restoring-divide iteration count (one per quotient bit)
package muldiv_pkg;

   localparam int OP_MULT   = 0;
   localparam int OP_MULTU  = 1;
   localparam int OP_DIV    = 2;
   localparam int OP_DIVU   = 3;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 5;

   typedef enum logic {
      IDLE = 1'b0,
      DIV  = 1'b1
   } state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem          in  partial remainder before this iteration
//   divisor      in  unsigned divisor magnitude
//   dividend_bit in  next dividend bit, MSB first
//   rem_next     out partial remainder after the trial subtraction
//   q_bit        out quotient bit produced by this iteration
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] divisor,
   input  logic              dividend_bit,
   output logic [DATA_W-1:0] rem_next,
   output logic              q_bit
);

   logic [DATA_W:0]   shifted;
   logic [DATA_W-1:0] diff;

   // When the subtraction succeeds the true difference is below the divisor,
   // so a DATA_W-bit modulo subtract yields it exactly.
   assign shifted  = {rem, dividend_bit};
   assign q_bit    = (shifted >= {1'b0, divisor});
   assign diff     = shifted[DATA_W-1:0] - divisor;
   assign rem_next = q_bit ? diff : shifted[DATA_W-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
//   clk, resetn          : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_op               : one-hot {divu, div, multu, mult}
//   src1, src2           : rs / rt operands
//   flush                : cancel in-flight or presented operation
//   mthi_we, mtlo_we     : write wdata into HI / LO when idle and not accepting
//   busy                 : unit occupied by a division
//   done                 : one-cycle pulse when HI/LO hold a new result
//   hi, lo               : architectural HI/LO registers
// Multiplies complete at the accept edge; divides take 32 restoring iterations.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic              flush,
   input  logic              mthi_we,
   input  logic              mtlo_we,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int PROD_W = 2 * DATA_W;

   function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
      return neg ? -v : v;
   endfunction

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt;
   logic                      accept, is_mul, is_div, last_iter;
   logic signed [PROD_W-1:0]  mul_a, mul_b, prod;
   logic [PROD_W-1:0]         rem_q;
   logic [DATA_W-1:0]         divisor;
   logic                      q_neg, r_neg;
   logic [DATA_W-1:0]         abs1, abs2;
   logic [DATA_W-1:0]         step_rem, quo_final, quo_fix, rem_fix;
   logic                      step_q;

   assign req_ready = (state == IDLE);
   assign busy      = ~req_ready;
   assign accept    = req_valid & req_ready & ~flush;
   assign is_mul    = req_op[OP_MULT] | req_op[OP_MULTU];
   assign is_div    = req_op[OP_DIV]  | req_op[OP_DIVU];
   assign last_iter = (cnt == CNT_W'(DIV_ITERS - 1));

   // One 64x64 multiplier serves both flavours: only the extension differs.
   assign mul_a = $signed({{DATA_W{req_op[OP_MULT] & src1[DATA_W-1]}}, src1});
   assign mul_b = $signed({{DATA_W{req_op[OP_MULT] & src2[DATA_W-1]}}, src2});
   assign prod  = mul_a * mul_b;

   assign abs1 = neg_if(req_op[OP_DIV] & src1[DATA_W-1], src1);
   assign abs2 = neg_if(req_op[OP_DIV] & src2[DATA_W-1], src2);

   // rem_q upper half is the partial remainder; lower half starts as the
   // dividend and fills with quotient bits as dividend bits shift out.
   div_step #(.DATA_W(DATA_W)) u_step (
      .rem          (rem_q[PROD_W-1:DATA_W]),
      .divisor      (divisor),
      .dividend_bit (rem_q[DATA_W-1]),
      .rem_next     (step_rem),
      .q_bit        (step_q)
   );

   assign quo_final = {rem_q[DATA_W-2:0], step_q};
   assign quo_fix   = neg_if(q_neg, quo_final);
   assign rem_fix   = neg_if(r_neg, step_rem);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && is_div) state_nxt = DIV;
         DIV:  if (flush || last_iter) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         if (state == IDLE) begin
            if (accept && is_mul) begin
               hi   <= prod[PROD_W-1:DATA_W];
               lo   <= prod[DATA_W-1:0];
               done <= 1'b1;
            end else if (accept && is_div) begin
               cnt <= '0;
            end else begin
               if (mthi_we) hi <= wdata;
               if (mtlo_we) lo <= wdata;
            end
         end else if (!flush) begin
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
               hi   <= rem_fix;
               lo   <= quo_fix;
               done <= 1'b1;
            end
         end
      end
   end

   // Divider datapath carries no reset; it is always reloaded on accept.
   // A zero divisor forces a positive quotient so lo reads all ones.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (accept && is_div) begin
            rem_q   <= {{DATA_W{1'b0}}, abs1};
            divisor <= abs2;
            q_neg   <= req_op[OP_DIV] & (src1[DATA_W-1] ^ src2[DATA_W-1]) & (|src2);
            r_neg   <= req_op[OP_DIV] & src1[DATA_W-1];
         end
      end else begin
         rem_q <= {step_rem, quo_final};
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

   localparam logic [3:0] OPC_MULT  = 4'b0001;
   localparam logic [3:0] OPC_MULTU = 4'b0010;
   localparam logic [3:0] OPC_DIV   = 4'b0100;
   localparam logic [3:0] OPC_DIVU  = 4'b1000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] src1, src2;
   logic        flush;
   logic        mthi_we, mtlo_we;
   logic [31:0] wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int lat, busy_n, done_n;

   always #5 clk = ~clk;

   muldiv_ctrl #(.DATA_W(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .mthi_we   (mthi_we),
      .mtlo_we   (mtlo_we),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present one divide, then wait (bounded) for done, counting busy cycles.
   task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output int nb);
      req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
      step;
      req_valid = 1'b0; req_op = 4'b0;
      n = 0; nb = 0;
      while (done !== 1'b1 && n < 40) begin
         if (req_ready === 1'b0) nb++;
         step;
         n++;
      end
   endtask

   initial begin
      resetn = 1'b0; req_valid = 1'b0; req_op = 4'b0; src1 = '0; src2 = '0;
      flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
      #12;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_ready", {31'b0, req_ready}, 32'h1);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      resetn = 1'b1;
      step;

      // MULT with a simultaneous MTHI: the product must win
      req_valid = 1'b1; req_op = OPC_MULT; src1 = 32'hFFFF_FFFF; src2 = 32'h2;
      mthi_we = 1'b1; wdata = 32'h0000_AAAA;
      step;
      mthi_we = 1'b0;
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);
      chk("mult_done", {31'b0, done}, 32'h1);
      chk("mult_ready", {31'b0, req_ready}, 32'h1);
      req_op = OPC_MULTU;
      step;
      chk("multu_hi", hi, 32'h1);
      chk("multu_lo", lo, 32'hFFFF_FFFE);
      chk("multu_done", {31'b0, done}, 32'h1);
      chk("multu_ready", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0; req_op = 4'b0;
      step;
      chk("mult_done_drop", {31'b0, done}, 32'h0);

      run_div(OPC_DIVU, 32'd100, 32'd7, lat, busy_n);
      chk("divu_lat", lat, 32);
      chk("divu_busy_cycles", busy_n, 32);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      chk("divu_ready", {31'b0, req_ready}, 32'h1);
      step;
      chk("divu_done_drop", {31'b0, done}, 32'h0);

      run_div(OPC_DIV, 32'hFFFF_FFF9, 32'd2, lat, busy_n);
      chk("div_neg_lat", lat, 32);
      chk("div_neg_lo", lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", hi, 32'hFFFF_FFFF);

      run_div(OPC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'h0);

      run_div(OPC_DIVU, 32'd5, 32'd0, lat, busy_n);
      chk("divu_z_lat", lat, 32);
      chk("divu_z_lo", lo, 32'hFFFF_FFFF);
      chk("divu_z_hi", hi, 32'd5);

      run_div(OPC_DIV, 32'hFFFF_FFF9, 32'd0, lat, busy_n);
      chk("div_z_lo", lo, 32'hFFFF_FFFF);
      chk("div_z_hi", hi, 32'hFFFF_FFF9);
      step;

      // preload HI/LO
      mthi_we = 1'b1; wdata = 32'h11;
      step;
      mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h22;
      step;
      mtlo_we = 1'b0;
      chk("mthi", hi, 32'h11);
      chk("mtlo", lo, 32'h22);

      // DIVU then flush 10 cycles after accept; MTHI while busy is ignored
      req_valid = 1'b1; req_op = OPC_DIVU; src1 = 32'd100; src2 = 32'd7;
      step;
      req_valid = 1'b0; req_op = 4'b0;
      chk("flush_busy", {31'b0, busy}, 32'h1);
      mthi_we = 1'b1; wdata = 32'h99;
      step;
      mthi_we = 1'b0;
      done_n = 0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1) done_n++;
         step;
      end
      flush = 1'b1;
      step;
      flush = 1'b0;
      chk("flush_ready", {31'b0, req_ready}, 32'h1);
      chk("flush_done", {31'b0, done}, 32'h0);
      chk("flush_hi", hi, 32'h11);
      chk("flush_lo", lo, 32'h22);
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) done_n++;
         step;
      end
      chk("flush_no_done", done_n, 0);
      chk("flush_hi_later", hi, 32'h11);

      // flush in IDLE blocks acceptance
      flush = 1'b1; req_valid = 1'b1; req_op = OPC_MULT; src1 = 32'd3; src2 = 32'd4;
      step;
      flush = 1'b0; req_valid = 1'b0; req_op = 4'b0;
      chk("idle_flush_done", {31'b0, done}, 32'h0);
      chk("idle_flush_lo", lo, 32'h22);

      // reset mid-division
      req_valid = 1'b1; req_op = OPC_DIVU; src1 = 32'd100; src2 = 32'd7;
      step;
      req_valid = 1'b0; req_op = 4'b0;
      for (int i = 0; i < 5; i++) step;
      resetn = 1'b0;
      #1;
      chk("mid_rst_hi", hi, 32'h0);
      chk("mid_rst_lo", lo, 32'h0);
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      chk("mid_rst_done", {31'b0, done}, 32'h0);
      resetn = 1'b1;
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         step;
         if (done === 1'b1) done_n++;
      end
      chk("post_rst_no_done", done_n, 0);

      req_valid = 1'b1; req_op = OPC_MULT; src1 = 32'd3; src2 = 32'd4;
      step;
      req_valid = 1'b0; req_op = 4'b0;
      chk("post_rst_mult_lo", lo, 32'd12);
      chk("post_rst_mult_hi", hi, 32'd0);
      chk("post_rst_mult_done", {31'b0, done}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. Sits beside the EX-stage ALU: accepts MULT/MULTU/DIV/DIVU requests through a valid/ready handshake, produces products in one cycle, and runs a 32-iteration restoring divider. It also services MTHI/MTLO writes, exposes HI/LO for MFHI/MFLO, and supports pipeline flush on exceptions.

## Interface
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX stage presents an operation.
- req_ready  out  1  unit idle and able to accept; `req_ready == (state == IDLE)`.
- req_op  in  4  one-hot `{divu, div, multu, mult}`; all-zero or multi-hot with req_valid is illegal.
- src1  in  DATA_W  rs value (dividend / multiplicand).
- src2  in  DATA_W  rt value (divisor / multiplier).
- flush  in  1  cancel any in-flight or presented operation.
- mthi_we, mtlo_we  in  1 each  write wdata into HI / LO.
- wdata  in  DATA_W  MTHI/MTLO data.
- busy  out  1  `~req_ready`.
- done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- hi, lo  out  DATA_W  architectural HI/LO registers.

## Operation
- **Accept condition:** the edge where `req_valid & req_ready & ~flush`.
- **MULT/MULTU:**
  - At the accept edge: `{hi,lo}` ← 64-bit signed (MULT) or unsigned (MULTU) product.
  - Register `done` ← 1. State stays IDLE.
- **DIV/DIVU:**
  - At the accept edge: latch |src1| and |src2| (raw values for DIVU), the quotient-sign flag (`src1[31]^src2[31]`, DIV only) and the remainder-sign flag (`src1[31]`, DIV only).
  - Clear the 64-bit partial remainder and the 5-bit counter. Go to DIV.
- **DIV state, per edge:** shift the partial remainder left by 1 and bring in the next dividend bit (MSB first). Trial-subtract the divisor. If non-negative, keep the difference and set the quotient bit. Then increment the counter.
- **Iteration 32** (counter == 31):
  - Apply sign correction. The quotient is negated if the quotient-sign flag is set; the remainder is negated if the remainder-sign flag is set.
  - Write lo ← quotient and hi ← remainder. Set `done` ← 1. Go to IDLE.
- **Divide by zero (src2 == 0):** always runs the full 32 iterations. Result is lo = 32'hFFFFFFFF and hi = src1 as supplied, for both DIV and DIVU.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This is the natural result; no special case is needed.
- **MTHI/MTLO:** honoured only in IDLE on an edge with no accept. They are ignored while in DIV and on an accept edge, where the operation result wins. Both may fire on the same edge.
- **flush:**
  - In DIV: next edge returns to IDLE. HI/LO are unchanged and no `done` is produced.
  - In IDLE: blocks acceptance that cycle.
- **States:** IDLE, DIV (2 states, 5-bit counter).

## Timing
- **Reset values (async, immediate on resetn low):** state IDLE, hi = 0, lo = 0, done = 0, counter = 0. Consequently req_ready = 1 and busy = 0.
- **resetn low mid-division:** the operation is lost; no `done` follows release.
- **MULT latency:** accept at edge T; hi/lo new and done = 1 in cycle T+1; req_ready stays 1.
- **DIV latency:** accept at edge T; req_ready = 0 for cycles T+1 … T+32; final write at edge T+32; done = 1 and req_ready = 1 in cycle T+33 (32 cycles after accept). A new request may be accepted at edge T+33.
- **done:** high for exactly one cycle per completed operation; never high after flush or reset.
- **MFHI/MFLO readiness:** hi/lo are plain register outputs. Consumers must stall on busy.

## Structure
- **Package `muldiv_pkg`:**
  - op bit indices OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3.
  - state enum {IDLE, DIV}.
  - DIV_ITERS = 32.
- **Sub-module `div_step`:** combinational single restoring iteration. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder, quotient bit. Instantiated once.
- **Top contents:** FSM, counter, HI/LO registers, sign handling, and the multiplier expression.

## Test plan
- MULT 0xFFFFFFFF × 2 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. MULTU with the same operands → hi = 1, lo = 0xFFFFFFFE. done is high in the cycle after accept; req_ready never drops.
- DIVU 100 / 7 → lo = 14, hi = 2. req_ready is low for exactly 32 cycles; done is high exactly 33 cycles after the accept cycle.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5.
- Preload hi = 0x11, lo = 0x22 via MTHI/MTLO. Start DIVU; assert flush after 10 cycles → no done, hi/lo remain 0x11/0x22, req_ready = 1 next cycle. Also check that mthi_we while busy is ignored.
- Drop resetn for 1 ns mid-division → hi = lo = 0, busy = 0 immediately. After release, a MULT 3 × 4 completes with lo = 12, hi = 0.
